// File: rtl/kharar_example.sv
// kharar_example: 8-bit accumulator ALU for a Tiny Tapeout slot. A rising strobe on uio_in[4] executes one op.
// Optional feature macro: KHARAR_OPCOUNT_EN adds an 8-bit op counter readable through opcode F.
module kharar_example (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_ROL  = 4'h9,
        OP_ROR  = 4'hA,
        OP_INC  = 4'hB,
        OP_DEC  = 4'hC,
        OP_NOT  = 4'hD,
        OP_CLR  = 4'hE,
        OP_CNT  = 4'hF
    } opcode_e;

    logic [7:0] acc_q;
    logic [7:0] acc_d;
    logic       carry_q;
    logic       carry_d;
    logic       strobePrev_q;
    logic       fire;
    opcode_e    opcode;
    logic [8:0] sum;
    logic [8:0] diff;
    logic [8:0] incSum;
    logic       unusedBits;

    assign opcode     = opcode_e'(uio_in[3:0]);
    assign fire       = uio_in[4] & ~strobePrev_q & ena;
    assign sum        = {1'b0, acc_q} + {1'b0, ui_in};
    assign diff       = {1'b0, acc_q} - {1'b0, ui_in};
    assign incSum     = {1'b0, acc_q} + 9'd1;
    assign unusedBits = ^uio_in[7:5];

`ifdef KHARAR_OPCOUNT_EN
    logic [7:0] opCount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opCount_q <= 8'h00;
        end else if (fire) begin
            opCount_q <= opCount_q + 8'd1;
        end
    end
`endif

    // diff[8] is the unsigned borrow of ACC-B.
    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        if (fire) begin
            case (opcode)
                OP_LOAD: acc_d = ui_in;
                OP_ADD:  {carry_d, acc_d} = sum;
                OP_SUB:  {carry_d, acc_d} = diff;
                OP_AND: begin
                    acc_d   = acc_q & ui_in;
                    carry_d = 1'b0;
                end
                OP_OR: begin
                    acc_d   = acc_q | ui_in;
                    carry_d = 1'b0;
                end
                OP_XOR: begin
                    acc_d   = acc_q ^ ui_in;
                    carry_d = 1'b0;
                end
                OP_SHL: begin
                    acc_d   = {acc_q[6:0], 1'b0};
                    carry_d = acc_q[7];
                end
                OP_SHR: begin
                    acc_d   = {1'b0, acc_q[7:1]};
                    carry_d = acc_q[0];
                end
                OP_ROL: begin
                    acc_d   = {acc_q[6:0], acc_q[7]};
                    carry_d = acc_q[7];
                end
                OP_ROR: begin
                    acc_d   = {acc_q[0], acc_q[7:1]};
                    carry_d = acc_q[0];
                end
                OP_INC:  {carry_d, acc_d} = incSum;
                OP_DEC: begin
                    acc_d   = acc_q - 8'd1;
                    carry_d = (acc_q == 8'h00);
                end
                OP_NOT:  acc_d = ~acc_q;
                OP_CLR: begin
                    acc_d   = 8'h00;
                    carry_d = 1'b0;
                end
`ifdef KHARAR_OPCOUNT_EN
                OP_CNT:  acc_d = opCount_q;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= 8'h00;
            carry_q      <= 1'b0;
            strobePrev_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            carry_q      <= carry_d;
            strobePrev_q <= uio_in[4];
        end
    end

    assign uo_out  = acc_q;
    assign uio_out = {acc_q[7], carry_q, (acc_q == 8'h00), 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_kharar_example.sv
// tb_kharar_example: directed and randomized checks of kharar_example against an arithmetic reference model.
// Honours KHARAR_OPCOUNT_EN the same way the design does.
module tb_kharar_example;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int compared;
    int mismatched;

    logic [7:0] mAcc;
    logic       mC;
    int         mCnt;

    kharar_example dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each opcode's effect written as plain integer arithmetic.
    task automatic modelFire(input logic [3:0] op, input logic [7:0] b);
        int a;
        int bb;
        int r;
        a  = int'(mAcc);
        bb = int'(b);
        r  = a;
        case (op)
            4'h1: r = bb;
            4'h2: begin r = (a + bb) % 256; mC = (a + bb) > 255; end
            4'h3: begin r = (a - bb + 256) % 256; mC = a < bb; end
            4'h4: begin r = a & bb; mC = 1'b0; end
            4'h5: begin r = a | bb; mC = 1'b0; end
            4'h6: begin r = a ^ bb; mC = 1'b0; end
            4'h7: begin r = (a * 2) % 256; mC = a >= 128; end
            4'h8: begin r = a / 2; mC = (a % 2) == 1; end
            4'h9: begin r = (a * 2) % 256 + a / 128; mC = a >= 128; end
            4'hA: begin r = a / 2 + (a % 2) * 128; mC = (a % 2) == 1; end
            4'hB: begin r = (a + 1) % 256; mC = a == 255; end
            4'hC: begin r = (a + 255) % 256; mC = a == 0; end
            4'hD: r = 255 - a;
            4'hE: begin r = 0; mC = 1'b0; end
`ifdef KHARAR_OPCOUNT_EN
            4'hF: r = mCnt;
`endif
            default: r = a;
        endcase
        mAcc = 8'(r);
        mCnt = (mCnt + 1) % 256;
    endtask

    task automatic modelReset();
        mAcc = 8'h00;
        mC   = 1'b0;
        mCnt = 0;
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] expFlags;
        expFlags = {mAcc[7], mC, (mAcc == 8'h00), 5'b00000};
        compared++;
        assert (uo_out === mAcc) else begin
            mismatched++;
            $error("[TB] FAIL %s acc observed=%02h expected=%02h", tag, uo_out, mAcc);
        end
        compared++;
        assert (uio_out === expFlags) else begin
            mismatched++;
            $error("[TB] FAIL %s flags observed=%02h expected=%02h", tag, uio_out, expFlags);
        end
    endtask

    task automatic checkConst(input string tag, input logic [7:0] expAcc, input logic expC);
        compared++;
        assert (uo_out === expAcc) else begin
            mismatched++;
            $error("[TB] FAIL %s acc observed=%02h required=%02h", tag, uo_out, expAcc);
        end
        compared++;
        assert (uio_out[6] === expC) else begin
            mismatched++;
            $error("[TB] FAIL %s carry observed=%0b required=%0b", tag, uio_out[6], expC);
        end
    endtask

    // One op: set up with strobe low, raise it for one cycle, check after the edge, drop it.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] b, input logic en);
        @(negedge clk);
        ena    = 1'b1;
        ui_in  = b;
        uio_in = {3'($urandom), 1'b0, op};
        @(negedge clk);
        ena       = en;
        uio_in[4] = 1'b1;
        @(negedge clk);
        if (en) modelFire(op, b);
        checkOutput($sformatf("op%0h_b%02h_en%0b", op, b, en));
        uio_in[4] = 1'b0;
        ena       = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b1;
        ena        = 1'b1;
        ui_in      = 8'h00;
        uio_in     = 8'h00;
        modelReset();

        doReset();
        applyStimulus(4'h1, 8'hA7, 1'b1);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        compared++;
        assert (uio_oe === 8'hE0) else begin
            mismatched++;
            $error("[TB] FAIL reset_oe observed=%02h required=e0", uio_oe);
        end
        compared++;
        assert (uio_out === 8'h20) else begin
            mismatched++;
            $error("[TB] FAIL reset_flags observed=%02h required=20", uio_out);
        end
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(4'h1, 8'hF0, 1'b1); checkConst("load_f0", 8'hF0, 1'b0);
        applyStimulus(4'h2, 8'h20, 1'b1); checkConst("add_20", 8'h10, 1'b1);
        applyStimulus(4'h2, 8'hF0, 1'b1); checkConst("add_f0", 8'h00, 1'b1);
        applyStimulus(4'h1, 8'h05, 1'b1);
        applyStimulus(4'h3, 8'h06, 1'b1); checkConst("sub_borrow", 8'hFF, 1'b1);
        applyStimulus(4'hE, 8'h00, 1'b1);
        applyStimulus(4'hC, 8'h00, 1'b1); checkConst("dec_wrap", 8'hFF, 1'b1);
        applyStimulus(4'hB, 8'h00, 1'b1); checkConst("inc_wrap", 8'h00, 1'b1);
        applyStimulus(4'h1, 8'h81, 1'b1);
        applyStimulus(4'h7, 8'h00, 1'b1); checkConst("shl_81", 8'h02, 1'b1);
        applyStimulus(4'h1, 8'h81, 1'b1);
        applyStimulus(4'hA, 8'h00, 1'b1); checkConst("ror_81", 8'hC0, 1'b1);
        applyStimulus(4'h8, 8'h00, 1'b1); checkConst("shr_c0", 8'h60, 1'b0);
        applyStimulus(4'h1, 8'h80, 1'b1);
        applyStimulus(4'h9, 8'h00, 1'b1); checkConst("rol_80", 8'h01, 1'b1);
        applyStimulus(4'h1, 8'hF5, 1'b1);
        applyStimulus(4'h4, 8'h0F, 1'b1); checkConst("and_0f", 8'h05, 1'b0);
        applyStimulus(4'h6, 8'hFF, 1'b1); checkConst("xor_ff", 8'hFA, 1'b0);
        applyStimulus(4'hD, 8'h00, 1'b1); checkConst("not_fa", 8'h05, 1'b0);

        // Strobe held high for ten cycles must execute exactly once.
        @(negedge clk);
        uio_in = 8'h0B;
        @(negedge clk);
        uio_in[4] = 1'b1;
        repeat (10) @(negedge clk);
        modelFire(4'hB, 8'h00);
        checkOutput("held_strobe");
        checkConst("held_strobe_const", 8'h06, 1'b0);
        uio_in[4] = 1'b0;

        applyStimulus(4'h1, 8'h33, 1'b0);
        checkConst("ena_low", 8'h06, 1'b0);

        // Reset while the strobe is held: one execution after release.
        @(negedge clk);
        ui_in  = 8'h9C;
        uio_in = 8'h11;
        @(negedge clk);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkConst("reset_held", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        modelFire(4'h1, 8'h9C);
        checkOutput("held_after_reset");
        repeat (3) @(negedge clk);
        checkConst("held_after_reset_once", 8'h9C, 1'b0);
        uio_in[4] = 1'b0;

        doReset();
        applyStimulus(4'h0, 8'h11, 1'b1);
        applyStimulus(4'h0, 8'h22, 1'b1);
        applyStimulus(4'h0, 8'h33, 1'b1);
`ifdef KHARAR_OPCOUNT_EN
        applyStimulus(4'hF, 8'h44, 1'b1); checkConst("opcnt_3", 8'h03, 1'b0);
        applyStimulus(4'hF, 8'h55, 1'b1); checkConst("opcnt_4", 8'h04, 1'b0);
`else
        applyStimulus(4'h1, 8'h5A, 1'b1);
        applyStimulus(4'hF, 8'h44, 1'b1); checkConst("opf_nop", 8'h5A, 1'b0);
`endif

        for (int i = 0; i < 80; i++) begin
            applyStimulus(4'($urandom), 8'($urandom), ($urandom_range(0, 9) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
